// File: rtl/piradip_axis_sample_buffer_seq_pkg.sv
// Shared types for the sample buffer playback sequencer.
// Sequencer state encoding and read-latency limits.
package piradip_sample_buffer;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DRAIN
  } seq_state_t;

  localparam int SEQ_MAX_READ_LATENCY = 4;

endpackage

// File: rtl/piradip_sample_buffer_skid_fifo.sv
// Small skid FIFO absorbing sample-RAM read latency.
// Ports: i_clk/i_rst_n, write side i_wr_en/i_wr_data,
// AXIS-style read side o_valid/i_ready/o_data, occupancy o_count.
module piradip_sample_buffer_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 129,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop   = o_valid && i_ready;
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Head entry is never overwritten: the writer
  // only targets free slots (credit-limited upstream).
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)   r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(i_wr_en) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/piradip_axis_sample_buffer_seq.sv
// Stream-side playback sequencer: RAM address generation,
// latency skid FIFO, AXIS manager output, stopped status.
module piradip_axis_sample_buffer_seq
  import piradip_sample_buffer::*;
#(
  parameter int STREAM_OFFSET_WIDTH = 5,
  parameter int DATA_WIDTH          = 128,
  parameter int READ_LATENCY        = 1
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           cfg_update,
  input  logic                           cfg_active,
  input  logic                           cfg_one_shot,
  input  logic [STREAM_OFFSET_WIDTH-1:0] cfg_start_offset,
  input  logic [STREAM_OFFSET_WIDTH-1:0] cfg_end_offset,
  output logic                           stopped,
  output logic                           mem_rden,
  output logic [STREAM_OFFSET_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [DATA_WIDTH-1:0]          m_tdata,
  output logic                           m_tlast
);

  localparam int W     = STREAM_OFFSET_WIDTH;
  localparam int RL    = READ_LATENCY;
  localparam int DEPTH = RL + 1;
  localparam int CW    = $clog2(DEPTH + 1);

  seq_state_t    r_state;
  logic [W-1:0]  r_addr;
  logic [W-1:0]  r_end;
  logic          r_one_shot;
  logic          r_pending;
  logic [RL-1:0] r_tag_vld;
  logic [RL-1:0] r_tag_last;
  logic [CW-1:0] r_inflight;

  logic [CW-1:0]   w_occ;
  logic [CW:0]     w_used;
  logic            w_credit;
  logic            w_issue;
  logic            w_start_req;
  logic            w_stop_req;
  logic            w_at_end;
  logic            w_pop;
  logic            w_wr;
  logic [DATA_WIDTH:0] w_fifo_out;

  assign w_start_req = cfg_update && cfg_active;
  assign w_stop_req  = cfg_update && !cfg_active;
  assign w_at_end    = (r_addr == r_end);
  assign w_pop       = m_tvalid && m_tready;
  assign w_wr        = r_tag_vld[RL-1];

  // A beat leaving this cycle frees its slot now,
  // which keeps one sample/cycle at depth RL+1.
  assign w_used   = (CW+1)'(r_inflight) + (CW+1)'(w_occ)
                  - (CW+1)'(w_pop);
  assign w_credit = (w_used < (CW+1)'(DEPTH));
  assign w_issue  = (r_state == SEQ_RUN) && !w_stop_req
                  && w_credit;

  assign stopped  = (r_state == SEQ_IDLE);
  assign mem_rden = w_issue;
  assign mem_addr = r_addr;
  assign m_tlast  = w_fifo_out[DATA_WIDTH];
  assign m_tdata  = w_fifo_out[DATA_WIDTH-1:0];

  // Read tags travel alongside the RAM pipeline.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tag_vld  <= '0;
      r_tag_last <= '0;
      r_inflight <= '0;
    end else begin
      r_tag_vld[0]  <= w_issue;
      r_tag_last[0] <= w_at_end;
      for (int i = 1; i < RL; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
      end
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_wr);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= SEQ_IDLE;
      r_addr     <= '0;
      r_end      <= '0;
      r_one_shot <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      unique case (r_state)
        SEQ_IDLE: begin
          if (w_start_req || r_pending) begin
            r_addr     <= cfg_start_offset;
            r_end      <= cfg_end_offset;
            r_one_shot <= cfg_one_shot;
            r_pending  <= 1'b0;
            r_state    <= SEQ_RUN;
          end
        end
        SEQ_RUN: begin
          if (w_stop_req) begin
            r_state <= SEQ_DRAIN;
          end else begin
            // Mode change lands at the next window end.
            if (w_start_req) r_one_shot <= cfg_one_shot;
            if (w_issue) begin
              if (!w_at_end) begin
                r_addr <= r_addr + 1'b1;
              end else if (r_one_shot) begin
                r_state <= SEQ_DRAIN;
              end else begin
                r_addr <= cfg_start_offset;
              end
            end
          end
        end
        SEQ_DRAIN: begin
          if (w_start_req)     r_pending <= 1'b1;
          else if (w_stop_req) r_pending <= 1'b0;
          if (r_inflight == '0 && w_occ == '0)
            r_state <= SEQ_IDLE;
        end
        default: r_state <= SEQ_IDLE;
      endcase
    end
  end

  piradip_sample_buffer_skid_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .i_clk     (aclk),
    .i_rst_n   (aresetn),
    .i_wr_en   (w_wr),
    .i_wr_data ({r_tag_last[RL-1], mem_rdata}),
    .o_valid   (m_tvalid),
    .i_ready   (m_tready),
    .o_data    (w_fifo_out),
    .o_count   (w_occ)
  );

endmodule
